// File: rtl/inst_capture.sv
// inst_capture: synchronises and debounces the step button, samples the
// instruction switches once per debounced press and offers the word to the
// sequencer on a valid/ready handshake. One instruction per physical press.
// Build option: define INST_CAPTURE_CNT_EN to add the inst_cnt transfer counter.
module inst_capture #(
    parameter int unsigned DB_CYCLES = 100000,
    parameter int unsigned CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnS,
    input  logic [7:0] sw,
    input  logic       inst_rdy,
    output logic       inst_vld,
    output logic [7:0] inst_wd,
`ifdef INST_CAPTURE_CNT_EN
    output logic [7:0] inst_cnt,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StPress,
        StFire,
        StHeld,
        StRelease
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    logic             r_btn_meta;
    logic             r_btn_s;
    logic [7:0]       r_sw_meta;
    logic [7:0]       r_sw_s;
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_wd;
    logic [7:0]       w_wd_nxt;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_sw_meta  <= 8'h00;
            r_sw_s     <= 8'h00;
        end else begin
            r_btn_meta <= btnS;
            r_btn_s    <= r_btn_meta;
            r_sw_meta  <= sw;
            r_sw_s     <= r_sw_meta;
        end
    end

    // FSM state, debounce counter and captured instruction word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_wd    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Next-state logic; a press must be stable DB_CYCLES clocks, and so must the release
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wd_nxt    = r_wd;
        case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (r_btn_s) begin
                    w_state_nxt = StPress;
                end
            end
            StPress: begin
                if (!r_btn_s) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CntMax) begin
                    w_state_nxt = StFire;
                    w_cnt_nxt   = '0;
                    w_wd_nxt    = r_sw_s;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            StFire: begin
                // Button state is ignored here so a release cannot cancel the transfer
                if (inst_rdy) begin
                    w_state_nxt = StHeld;
                end
            end
            StHeld: begin
                if (!r_btn_s) begin
                    w_state_nxt = StRelease;
                    w_cnt_nxt   = '0;
                end
            end
            StRelease: begin
                if (r_btn_s) begin
                    w_state_nxt = StHeld;
                end else if (r_cnt == CntMax) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign inst_vld = (r_state == StFire);
    assign inst_wd  = r_wd;
    assign busy     = (r_state != StIdle);

`ifdef INST_CAPTURE_CNT_EN
    logic [7:0] r_inst_cnt;

    // Count completed transfers, wrapping at 256
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_cnt <= 8'h00;
        end else if (inst_vld && inst_rdy) begin
            r_inst_cnt <= r_inst_cnt + 8'd1;
        end
    end

    assign inst_cnt = r_inst_cnt;
`endif

endmodule

// File: tb/tb_inst_capture.sv
// Directed bench for inst_capture with DB_CYCLES=16.
module tb_inst_capture;

    logic       clk;
    logic       rst;
    logic       btnS;
    logic [7:0] sw;
    logic       inst_rdy;
    logic       inst_vld;
    logic [7:0] inst_wd;
    logic       busy;
`ifdef INST_CAPTURE_CNT_EN
    logic [7:0] inst_cnt;
    logic       btn1;
    logic       vld1;
    logic [7:0] wd1;
    logic       busy1;
    logic [7:0] cnt1;
`endif

    int total = 0;
    int bad   = 0;

    inst_capture #(
        .DB_CYCLES(16),
        .CNT_W    (5)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .btnS    (btnS),
        .sw      (sw),
        .inst_rdy(inst_rdy),
        .inst_vld(inst_vld),
        .inst_wd (inst_wd),
`ifdef INST_CAPTURE_CNT_EN
        .inst_cnt(inst_cnt),
`endif
        .busy    (busy)
    );

`ifdef INST_CAPTURE_CNT_EN
    inst_capture #(
        .DB_CYCLES(1),
        .CNT_W    (1)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .btnS    (btn1),
        .sw      (sw),
        .inst_rdy(1'b1),
        .inst_vld(vld1),
        .inst_wd (wd1),
        .inst_cnt(cnt1),
        .busy    (busy1)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick n times, counting rising edges of inst_vld
    task automatic count_pulses(input int n, output int pulses);
        logic prev;
        prev   = inst_vld;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (inst_vld && !prev) pulses++;
            prev = inst_vld;
        end
    endtask

    logic [7:0] seq [10];
    int         np;
    int         hi;
    logic       seen;

    initial begin
        seq = '{8'h04, 8'h00, 8'h13, 8'h86, 8'h4B, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h5A};
        rst      = 1'b1;
        btnS     = 1'b0;
        sw       = 8'h00;
        inst_rdy = 1'b1;
`ifdef INST_CAPTURE_CNT_EN
        btn1 = 1'b0;
`endif
        ticks(3);
        check("rst_vld", inst_vld, 0);
        check("rst_wd", inst_wd, 8'h00);
        check("rst_busy", busy, 0);
`ifdef INST_CAPTURE_CNT_EN
        check("rst_cnt", inst_cnt, 8'h00);
`endif
        rst = 1'b0;
        ticks(2);

        // Clean press: pulse exactly at edge 19, one cycle wide
        sw   = 8'b0000_0100;
        btnS = 1'b1;
        ticks(2);
        check("clean_idle_e2", busy, 0);
        tick();
        check("clean_press_e3", busy, 1);
        ticks(15);
        check("clean_vld_e18", inst_vld, 0);
        tick();
        check("clean_vld_e19", inst_vld, 1);
        check("clean_wd", inst_wd, 8'h04);
        tick();
        check("clean_vld_e20", inst_vld, 0);
        count_pulses(80, np);
        check("clean_no_repeat", np, 0);
        check("clean_held_busy", busy, 1);
        btnS = 1'b0;
        ticks(18);
        check("rel_busy_e18", busy, 1);
        tick();
        check("rel_busy_e19", busy, 0);
        ticks(3);

        // Bounce on press then hold high
        sw = 8'hA5;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            btnS = ((i / 3) % 2) == 0;
            tick();
            if (inst_vld) np++;
        end
        check("bounce_press_none", np, 0);
        btnS = 1'b1;
        ticks(18);
        check("bounce_vld_e18", inst_vld, 0);
        tick();
        check("bounce_vld_e19", inst_vld, 1);
        check("bounce_wd", inst_wd, 8'hA5);
        count_pulses(40, np);
        check("bounce_single", np, 0);
        np = 0;
        for (int i = 0; i < 40; i++) begin
            btnS = ((i / 3) % 2) == 1;
            tick();
            if (inst_vld) np++;
        end
        btnS = 1'b0;
        count_pulses(30, hi);
        check("bounce_release_none", np + hi, 0);
        check("bounce_release_idle", busy, 0);

        // Backpressure: inst_rdy low for 10 clocks after FIRE is entered
        sw       = 8'h3C;
        inst_rdy = 1'b0;
        btnS     = 1'b1;
        ticks(19);
        check("bp_vld_enter", inst_vld, 1);
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) sw = 8'hFF;
            if (i == 5) btnS = 1'b0;
            tick();
            if (inst_vld && inst_wd == 8'h3C) hi++;
        end
        inst_rdy = 1'b1;
        tick();
        check("bp_vld_width", hi, 11);
        check("bp_vld_drop", inst_vld, 0);
        check("bp_wd_hold", inst_wd, 8'h3C);
        ticks(40);
        check("bp_idle", busy, 0);

        // Reset while FIRE is waiting on inst_rdy
        sw       = 8'h81;
        inst_rdy = 1'b0;
        btnS     = 1'b1;
        ticks(19);
        check("rf_vld_pre", inst_vld, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rf_vld", inst_vld, 0);
        check("rf_wd", inst_wd, 8'h00);
        check("rf_busy", busy, 0);
        ticks(18);
        check("rf_vld_e18", inst_vld, 0);
        tick();
        check("rf_vld_e19", inst_vld, 1);
        check("rf_wd_new", inst_wd, 8'h81);
        inst_rdy = 1'b1;
        tick();
        check("rf_vld_done", inst_vld, 0);
        btnS = 1'b0;
        ticks(30);

        // Sequence of ten instructions from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            sw   = seq[i];
            btnS = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                tick();
                if (inst_vld) seen = 1'b1;
            end
            check($sformatf("seq%0d_vld", i), seen, 1);
            check($sformatf("seq%0d_wd", i), inst_wd, seq[i]);
            btnS = 1'b0;
            ticks(25);
            check($sformatf("seq%0d_idle", i), busy, 0);
        end
`ifdef INST_CAPTURE_CNT_EN
        check("seq_cnt", inst_cnt, 8'd10);

        // 257 presses on the DB_CYCLES=1 instance wrap the counter to 1
        for (int i = 0; i < 257; i++) begin
            btn1 = 1'b1;
            ticks(6);
            btn1 = 1'b0;
            ticks(6);
        end
        check("wrap_cnt", cnt1, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
